// File: rtl/namuru_pkg.sv
// -----------------------------------------------------------------------------
// namuru_pkg
// Shared definitions for the Namuru correlator accumulator reader:
//   - state_t     : reader FSM state encoding (IDLE, REQ, PUSH, GAP)
//   - DEF_*       : default parameter values used by namuru_accum_reader
//   - word_adr()  : byte address of 32-bit register number idx above a base
// -----------------------------------------------------------------------------
package namuru_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        PUSH = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [31:0] DEF_BASE_ADR   = 32'h0000_0000;
    localparam int          DEF_NUM_WORDS  = 16;
    localparam int          DEF_GAP_CYCLES = 8;
    localparam int          DEF_TIMEOUT    = 255;

    // 32-bit arithmetic, so the address wraps modulo 2^32.
    function automatic logic [31:0] word_adr(input logic [31:0] base, input logic [7:0] idx);
        return base + {22'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/namuru_edge_sync.sv
// -----------------------------------------------------------------------------
// namuru_edge_sync
// Two-flop synchroniser followed by a rising-edge detector.
// Ports:
//   clk     in   sampling clock
//   srst    in   synchronous active-high reset
//   async_i in   asynchronous level input
//   rise_o  out  one-cycle pulse on a synchronised low-to-high transition
// -----------------------------------------------------------------------------
module namuru_edge_sync (
    input  logic clk,
    input  logic srst,
    input  logic async_i,
    output logic rise_o
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       hist_q,  hist_d;
    logic [1:0] fill_q,  fill_d;

    // The history flop is held at 1 until the synchroniser chain has been
    // refilled after reset. A level that was already high across reset release
    // therefore never looks like an edge; a genuine low phase is required.
    always_comb begin
        sync1_d = async_i;
        sync2_d = sync1_q;
        fill_d  = {fill_q[0], 1'b1};
        hist_d  = fill_q[1] ? sync2_q : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b1;
            fill_q  <= 2'b00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
        end
    end

    assign rise_o = fill_q[1] & sync2_q & ~hist_q;

endmodule

// File: rtl/namuru_accum_reader.sv
// -----------------------------------------------------------------------------
// namuru_accum_reader
// On each (enabled) accumulation interrupt, reads NUM_WORDS consecutive 32-bit
// correlator registers over a Wishbone master port and streams them out one
// word at a time with valid/ready handshaking.
// Ports:
//   sys_clk, sys_rst        clock, synchronous active-high reset
//   accum_int, enable       asynchronous interrupt, trigger arm
//   wb_*                    Wishbone master (read-only, single-beat cycles)
//   dump_dat/idx/valid/last read-data stream out, dump_ready back-pressure in
//   busy                    low only while idle
//   overrun, timeout_err    sticky status flags, cleared by err_clr
// -----------------------------------------------------------------------------
module namuru_accum_reader
    import namuru_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = DEF_BASE_ADR,
    parameter int          NUM_WORDS  = DEF_NUM_WORDS,
    parameter int          GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int          TIMEOUT    = DEF_TIMEOUT
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        accum_int,
    input  logic        enable,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic        wb_we_o,
    input  logic        wb_ack_i,
    output logic [31:0] dump_dat,
    output logic [7:0]  dump_idx,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic        dump_last,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err,
    input  logic        err_clr
);

    localparam logic [7:0]  LAST_IDX = 8'(NUM_WORDS - 1);
    localparam logic [31:0] TO_LIM   = 32'(TIMEOUT);
    localparam logic [31:0] GAP_LIM  = 32'(GAP_CYCLES);

    logic   int_rise;
    logic   trigger;

    state_t      state_q,  state_d;
    logic [7:0]  idx_q,    idx_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic        abort_q,  abort_d;
    logic [31:0] adr_q,    adr_d;
    logic [3:0]  sel_q,    sel_d;
    logic        bus_q,    bus_d;
    logic [31:0] dat_q,    dat_d;
    logic [7:0]  didx_q,   didx_d;
    logic        valid_q,  valid_d;
    logic        last_q,   last_d;
    logic        busy_q,   busy_d;
    logic        ovr_q,    ovr_d;
    logic        toerr_q,  toerr_d;
    logic        ovr_set;
    logic        toerr_set;

    namuru_edge_sync u_int_sync (
        .clk     (sys_clk),
        .srst    (sys_rst),
        .async_i (accum_int),
        .rise_o  (int_rise)
    );

    assign trigger = int_rise & enable;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        abort_d   = abort_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        didx_d    = didx_q;
        last_d    = last_q;
        ovr_set   = 1'b0;
        toerr_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    idx_d   = 8'd0;
                    abort_d = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // An ack in the final allowed cycle still counts as success.
                if (wb_ack_i) begin
                    dat_d   = wb_dat_i;
                    didx_d  = idx_q;
                    last_d  = (idx_q == LAST_IDX);
                    state_d = PUSH;
                end else if (to_cnt_q + 32'd1 >= TO_LIM) begin
                    toerr_set = 1'b1;
                    abort_d   = 1'b1;
                    gap_cnt_d = 32'd0;
                    state_d   = GAP;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                end
            end
            PUSH: begin
                if (dump_ready) begin
                    gap_cnt_d = 32'd0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                // The slave is resynchronised, so stb must be seen low for the
                // whole gap before the next cycle may start.
                if (gap_cnt_q + 32'd1 >= GAP_LIM) begin
                    if (abort_q || (idx_q == LAST_IDX)) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = REQ;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (trigger && (state_q != IDLE)) begin
            ovr_set = 1'b1;
        end

        if ((state_d == REQ) && (state_q != REQ)) begin
            to_cnt_d = 32'd0;
            adr_d    = word_adr(BASE_ADR, idx_d);
        end

        if (state_d != PUSH) begin
            last_d = 1'b0;
        end

        // Outputs are registered from the next state so they line up with it.
        bus_d   = (state_d == REQ);
        sel_d   = bus_d ? 4'hF : 4'h0;
        valid_d = (state_d == PUSH);
        busy_d  = (state_d != IDLE);

        // A set in the same cycle as err_clr wins.
        ovr_d   = ovr_set   | (ovr_q   & ~err_clr);
        toerr_d = toerr_set | (toerr_q & ~err_clr);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            idx_q     <= 8'd0;
            to_cnt_q  <= 32'd0;
            gap_cnt_q <= 32'd0;
            abort_q   <= 1'b0;
            adr_q     <= 32'd0;
            sel_q     <= 4'h0;
            bus_q     <= 1'b0;
            dat_q     <= 32'd0;
            didx_q    <= 8'd0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
            toerr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            abort_q   <= abort_d;
            adr_q     <= adr_d;
            sel_q     <= sel_d;
            bus_q     <= bus_d;
            dat_q     <= dat_d;
            didx_q    <= didx_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
            toerr_q   <= toerr_d;
        end
    end

    assign wb_adr_o    = adr_q;
    assign wb_sel_o    = sel_q;
    assign wb_stb_o    = bus_q;
    assign wb_cyc_o    = bus_q;
    assign wb_we_o     = 1'b0;
    assign dump_dat    = dat_q;
    assign dump_idx    = didx_q;
    assign dump_valid  = valid_q;
    assign dump_last   = last_q;
    assign busy        = busy_q;
    assign overrun     = ovr_q;
    assign timeout_err = toerr_q;

endmodule
